mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) round-robin arbiter onto a single synchronous memory bus.
// Each access is ACCESS (strobe + grant) followed by DONE (read data returned).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_dma;
    logic                  r_id_dma;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_cpu_gnt;
    logic                  r_dma_gnt;
    logic                  r_cpu_rvalid;
    logic                  r_dma_rvalid;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_any_req;
    logic                  w_pick_dma;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // On a tie the side that was not granted last wins.
    always_comb begin
        w_any_req  = cpu_req | dma_req;
        w_pick_dma = dma_req & (~cpu_req | ~r_last_dma);
        w_we       = w_pick_dma ? dma_we    : cpu_we;
        w_addr     = w_pick_dma ? dma_addr  : cpu_addr;
        w_wdata    = w_pick_dma ? dma_wdata : cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_last_dma    <= 1'b1;
            r_id_dma      <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cpu_gnt     <= 1'b0;
            r_dma_gnt     <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_cpu_gnt     <= 1'b0;
            r_dma_gnt     <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;

            unique case (r_state)
                StIdle, StDone: begin
                    if (w_any_req) begin
                        r_state       <= StAccess;
                        r_last_dma    <= w_pick_dma;
                        r_id_dma      <= w_pick_dma;
                        r_we          <= w_we;
                        r_addr        <= w_addr;
                        r_wdata       <= w_wdata;
                        // Bus outputs are registered, so they come up with ACCESS.
                        r_cpu_gnt     <= ~w_pick_dma;
                        r_dma_gnt     <= w_pick_dma;
                        r_mem_read    <= ~w_we;
                        r_mem_write   <= w_we;
                        r_mem_address <= w_addr;
                        r_mem_wdata   <= w_wdata;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StAccess: begin
                    r_state      <= StDone;
                    r_cpu_rvalid <= ~r_we & ~r_id_dma;
                    r_dma_rvalid <= ~r_we & r_id_dma;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cpu_gnt     = r_cpu_gnt;
    assign dma_gnt     = r_dma_gnt;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign dma_rvalid  = r_dma_rvalid;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    // Memory data passes straight through during DONE; held at 0 otherwise.
    assign rdata       = (r_cpu_rvalid | r_dma_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle-latency memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0]  rdata;
    logic [15:0] mem_address;
    logic        mem_read, mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .rdata      (rdata),
        .mem_address(mem_address),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a == 16'hF000) return 8'hF5;
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem_model(mem_address);
    end

    logic [37:0] all_outs;
    assign all_outs = {cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
                       mem_address, mem_read, mem_write, mem_wdata};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

        // Reset low for two cycles, then idle with no strobes
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'(all_outs), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outs_1", 64'(all_outs), 64'd0);
        @(negedge clk);
        chk("idle_outs_2", 64'(all_outs), 64'd0);

        // CPU read of F000
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hF000;
        @(negedge clk);
        chk("cpu_rd_gnt", 64'(cpu_gnt), 64'd1);
        chk("cpu_rd_mread", 64'({mem_read, mem_write}), 64'b10);
        chk("cpu_rd_addr", 64'(mem_address), 64'hF000);
        chk("cpu_rd_dgnt", 64'(dma_gnt), 64'd0);
        cpu_req = 0; cpu_addr = 16'h1234;   // must not disturb the in-flight access
        @(negedge clk);
        chk("cpu_rd_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'b10);
        chk("cpu_rd_rdata", 64'(rdata), 64'hF5);
        chk("cpu_rd_done_strobes", 64'({cpu_gnt, mem_read, mem_write, mem_address}), 64'd0);
        @(negedge clk);
        chk("cpu_rd_after", 64'(all_outs), 64'd0);

        // DMA write of 55 to 0010
        dma_req = 1; dma_we = 1; dma_addr = 16'h0010; dma_wdata = 8'h55;
        @(negedge clk);
        chk("dma_wr_gnt", 64'({cpu_gnt, dma_gnt}), 64'b01);
        chk("dma_wr_strobes", 64'({mem_read, mem_write}), 64'b01);
        chk("dma_wr_addr", 64'(mem_address), 64'h0010);
        chk("dma_wr_data", 64'(mem_wdata), 64'h55);
        dma_req = 0; dma_wdata = 8'hAA;
        @(negedge clk);
        chk("dma_wr_norvalid", 64'({cpu_rvalid, dma_rvalid}), 64'b00);
        chk("dma_wr_done_outs", 64'(all_outs), 64'd0);
        @(negedge clk);

        // DMA read of 0033
        dma_req = 1; dma_we = 0; dma_addr = 16'h0033;
        @(negedge clk);
        chk("dma_rd_gnt", 64'({dma_gnt, mem_read, mem_address}), {47'd0, 1'b1, 1'b1, 16'h0033});
        dma_req = 0;
        @(negedge clk);
        chk("dma_rd_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'b01);
        chk("dma_rd_rdata", 64'(rdata), 64'h96);
        @(negedge clk);

        // Both requesting from reset: CPU, DMA, CPU, DMA with a grant every 2 cycles
        reset = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0002;
        repeat (2) @(negedge clk);
        chk("tie_reset_outs", 64'(all_outs), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tie_gnt_%0d", i), 64'({cpu_gnt, dma_gnt}),
                (i % 2 == 0) ? 64'b10 : 64'b01);
            chk($sformatf("tie_addr_%0d", i), 64'(mem_address),
                (i % 2 == 0) ? 64'h0001 : 64'h0002);
            @(negedge clk);
            chk($sformatf("tie_done_gnt_%0d", i), 64'({cpu_gnt, dma_gnt}), 64'b00);
            chk($sformatf("tie_rvalid_%0d", i), 64'({cpu_rvalid, dma_rvalid}),
                (i % 2 == 0) ? 64'b10 : 64'b01);
            chk($sformatf("tie_rdata_%0d", i), 64'(rdata),
                (i % 2 == 0) ? 64'(8'h01 ^ 8'hA5) : 64'(8'h02 ^ 8'hA5));
        end
        cpu_req = 0; dma_req = 0;
        @(negedge clk);
        chk("tie_idle", 64'(all_outs), 64'd0);

        // Reset during a CPU read ACCESS abandons it; a tie afterwards grants CPU first
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hF000;
        @(negedge clk);
        chk("abort_gnt", 64'(cpu_gnt), 64'd1);
        reset = 1'b0; cpu_req = 0;
        @(negedge clk);
        chk("abort_outs", 64'(all_outs), 64'd0);
        cpu_req = 1; cpu_addr = 16'hF000;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0044; dma_wdata = 8'h3C;
        @(negedge clk);
        chk("abort_outs_2", 64'(all_outs), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_tie", 64'({cpu_gnt, dma_gnt}), 64'b10);
        cpu_req = 0;
        @(negedge clk);
        chk("post_reset_rvalid", 64'({cpu_rvalid, dma_rvalid, rdata}), {54'd0, 2'b10, 8'hF5});
        @(negedge clk);
        chk("post_reset_dma", 64'({dma_gnt, mem_write, mem_address, mem_wdata}),
            {38'd0, 1'b1, 1'b1, 16'h0044, 8'h3C});
        dma_req = 0;
        @(negedge clk);
        chk("post_reset_dma_done", 64'(all_outs), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
